// File: rtl/fmap_job_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : fmap_job_sequencer
//  Purpose  : Runs a batch of 1..MAX_JOBS images through the pixel-ROM feeder
//             and the CNN. For each job it selects the image, fires a
//             one-cycle feeder start, counts streamed pixels, waits for the
//             class result and stores it. A job that stalls for TIMEOUT idle
//             cycles stores all-ones and raises the sticky error flag.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk            in   clock, all state on the rising edge
//    reset          in   asynchronous active-high reset
//    i_start        in   batch start, only honoured while idle
//    i_base_sel     in   first image index (reduced modulo NUM_SEL)
//    i_num_jobs     in   images per batch (0 -> 1, >MAX_JOBS -> MAX_JOBS)
//    o_sel          out  image select to the feeder, held for a whole job
//    o_feed_valid   out  one-cycle feeder start pulse
//    i_pix_valid    in   feeder pixel strobe
//    i_result_valid in   CNN result strobe
//    i_result       in   CNN class
//    o_busy         out  batch in progress
//    o_done         out  one-cycle batch-complete pulse
//    o_job_idx      out  current job index (0 while idle)
//    o_results      out  job k result at [k*CLASS_BW +: CLASS_BW]
//    o_err          out  sticky per-batch timeout flag
// ============================================================================
module fmap_job_sequencer #(
  parameter int TOTAL_PIXELS = 784,
  parameter int SEL_BW       = 4,
  parameter int NUM_SEL      = 12,
  parameter int CLASS_BW     = 4,
  parameter int MAX_JOBS     = 4,
  parameter int TIMEOUT      = 4095,
  parameter int GAP          = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         i_start,
  input  logic [SEL_BW-1:0]            i_base_sel,
  input  logic [2:0]                   i_num_jobs,
  output logic [SEL_BW-1:0]            o_sel,
  output logic                         o_feed_valid,
  input  logic                         i_pix_valid,
  input  logic                         i_result_valid,
  input  logic [CLASS_BW-1:0]          i_result,
  output logic                         o_busy,
  output logic                         o_done,
  output logic [1:0]                   o_job_idx,
  output logic [MAX_JOBS*CLASS_BW-1:0] o_results,
  output logic                         o_err
);

  localparam int PIX_W  = $clog2(TOTAL_PIXELS + 1);
  localparam int TMR_W  = $clog2(TIMEOUT + 1);
  localparam int GAP_W  = $clog2(GAP + 2);
  localparam int SELX_W = SEL_BW + 1;

  localparam logic [PIX_W-1:0]  LAST_PIX = PIX_W'(TOTAL_PIXELS - 1);
  localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(TIMEOUT - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST = GAP_W'((GAP > 0) ? GAP - 1 : 0);
  localparam logic [SEL_BW-1:0] SEL_LAST = SEL_BW'(NUM_SEL - 1);
  localparam logic [SELX_W-1:0] SEL_MOD  = SELX_W'(NUM_SEL);
  localparam logic [2:0]        MAX_N    = 3'(MAX_JOBS);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LAUNCH   = 3'd1,
    STREAM   = 3'd2,
    WAIT_RES = 3'd3,
    STORE    = 3'd4,
    GAP_WAIT = 3'd5,
    DONE     = 3'd6
  } state_t;

  state_t              state, state_nxt;
  logic [1:0]          job;
  logic [1:0]          last_job;
  logic [PIX_W-1:0]    pix_cnt;
  logic [TMR_W-1:0]    timer;
  logic [GAP_W-1:0]    gap_cnt;
  logic [CLASS_BW-1:0] res_cap;
  logic                job_err;
  logic [2:0]          num_clamped;
  logic [SEL_BW-1:0]   base_mod;

  // The timer holds the number of idle cycles already elapsed, so the
  // TIMEOUT-th consecutive idle cycle is the one that sees TMR_LAST.
  logic tmr_hit;
  logic pix_last;
  assign tmr_hit  = (timer == TMR_LAST);
  assign pix_last = (pix_cnt == LAST_PIX);

  always_comb begin
    num_clamped = i_num_jobs;
    if (i_num_jobs == 3'd0) begin
      num_clamped = 3'd1;
    end else if (i_num_jobs > MAX_N) begin
      num_clamped = MAX_N;
    end
  end

  // One spare bit keeps the modulus non-zero when NUM_SEL == 2**SEL_BW.
  assign base_mod = SEL_BW'({1'b0, i_base_sel} % SEL_MOD);

  assign o_job_idx = (state == IDLE) ? 2'd0 : job;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    o_feed_valid = 1'b0;
    o_busy       = 1'b0;
    o_done       = 1'b0;
    case (state)
      IDLE: begin
        if (i_start) state_nxt = LAUNCH;
      end
      LAUNCH: begin
        o_feed_valid = 1'b1;
        o_busy       = 1'b1;
        state_nxt    = STREAM;
      end
      STREAM: begin
        o_busy = 1'b1;
        if (i_pix_valid) begin
          if (pix_last) state_nxt = WAIT_RES;
        end else if (tmr_hit) begin
          state_nxt = STORE;
        end
      end
      WAIT_RES: begin
        o_busy = 1'b1;
        if (i_result_valid || tmr_hit) state_nxt = STORE;
      end
      STORE: begin
        o_busy = 1'b1;
        if (job == last_job) begin
          state_nxt = DONE;
        end else if (GAP == 0) begin
          state_nxt = LAUNCH;
        end else begin
          state_nxt = GAP_WAIT;
        end
      end
      GAP_WAIT: begin
        o_busy = 1'b1;
        if (gap_cnt == GAP_LAST) state_nxt = LAUNCH;
      end
      DONE: begin
        o_done    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_sel     <= '0;
      o_results <= '0;
      o_err     <= 1'b0;
      job       <= 2'd0;
      last_job  <= 2'd0;
      pix_cnt   <= '0;
      timer     <= '0;
      gap_cnt   <= '0;
      res_cap   <= '0;
      job_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_start) begin
            o_sel     <= base_mod;
            last_job  <= 2'(num_clamped - 3'd1);
            o_results <= '0;
            o_err     <= 1'b0;
            job       <= 2'd0;
          end
        end
        LAUNCH: begin
          pix_cnt <= '0;
          timer   <= '0;
          job_err <= 1'b0;
          res_cap <= '0;
        end
        STREAM: begin
          if (i_pix_valid) begin
            pix_cnt <= pix_cnt + PIX_W'(1);
            timer   <= '0;
          end else if (tmr_hit) begin
            job_err <= 1'b1;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end
        WAIT_RES: begin
          if (i_result_valid) begin
            res_cap <= i_result;
          end else if (tmr_hit) begin
            job_err <= 1'b1;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end
        STORE: begin
          for (int k = 0; k < MAX_JOBS; k++) begin
            if (job == 2'(k)) begin
              o_results[k*CLASS_BW +: CLASS_BW] <= job_err ? {CLASS_BW{1'b1}} : res_cap;
            end
          end
          if (job_err) o_err <= 1'b1;
          if (job != last_job) begin
            job     <= job + 2'd1;
            // Stepping the select with wrap equals (base + job) mod NUM_SEL
            // because the latched base is already below NUM_SEL.
            o_sel   <= (o_sel == SEL_LAST) ? '0 : o_sel + SEL_BW'(1);
            gap_cnt <= '0;
          end
        end
        GAP_WAIT: begin
          gap_cnt <= gap_cnt + GAP_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fmap_job_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_fmap_job_sequencer
//  Purpose  : Self-checking bench for fmap_job_sequencer. A transaction-level
//             model predicts launch cycles, selects, done cycle and packed
//             results from the stimulus timing; a per-cycle compare process
//             checks the DUT against it. Literal checks pin key results.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fmap_job_sequencer;

  localparam int TOTAL     = 784;
  localparam int NUM_SEL   = 12;
  localparam int TIMEOUT   = 4095;
  localparam int GAP       = 2;
  localparam int MAXJ      = 4;
  localparam int BIG       = 32'h7fffffff;
  localparam int FEED_WAIT = TIMEOUT + 64;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        i_start = 1'b0;
  logic [3:0]  i_base_sel = '0;
  logic [2:0]  i_num_jobs = '0;
  logic [3:0]  o_sel;
  logic        o_feed_valid;
  logic        i_pix_valid = 1'b0;
  logic        i_result_valid = 1'b0;
  logic [3:0]  i_result = '0;
  logic        o_busy;
  logic        o_done;
  logic [1:0]  o_job_idx;
  logic [15:0] o_results;
  logic        o_err;

  fmap_job_sequencer #(
    .TOTAL_PIXELS(TOTAL), .SEL_BW(4), .NUM_SEL(NUM_SEL), .CLASS_BW(4),
    .MAX_JOBS(MAXJ), .TIMEOUT(TIMEOUT), .GAP(GAP)
  ) dut (
    .clk(clk), .reset(reset), .i_start(i_start), .i_base_sel(i_base_sel),
    .i_num_jobs(i_num_jobs), .o_sel(o_sel), .o_feed_valid(o_feed_valid),
    .i_pix_valid(i_pix_valid), .i_result_valid(i_result_valid),
    .i_result(i_result), .o_busy(o_busy), .o_done(o_done),
    .o_job_idx(o_job_idx), .o_results(o_results), .o_err(o_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  function automatic void chk(string nm, longint a, longint e);
    n_checks++;
    if (a == e) n_pass++;
    else $display("FAIL %s: got %0h, want %0h (cycle %0d)", nm, a, e, cyc);
  endfunction

  // ---------------- model state ----------------
  bit          chk_en = 1'b0;
  bit          m_active = 1'b0;
  int          m_start_cyc = -1;
  int          m_done_cyc = -1;
  int          m_base = 0;
  int          m_njobs = 1;
  logic [15:0] m_results = '0;
  bit          m_err = 1'b0;
  int          feed_sel[int];
  int          feed_job[int];
  int          m_cur_sel = 0;
  int          m_cur_from = -1;
  int          m_cur_until = -1;
  int          seen_sel[$];

  // ---------------- per-test stimulus config ----------------
  int          stall_after[MAXJ];
  logic [3:0]  res_val[MAXJ];
  int          res_delay[MAXJ];
  bit          stray_en, busy_start_en, dup_en;
  logic [3:0]  dup_val;
  int          abort_job, abort_pix;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_cfg();
    for (int i = 0; i < MAXJ; i++) begin
      stall_after[i] = -1;
      res_val[i]     = 4'h0;
      res_delay[i]   = 20;
    end
    stray_en = 0; busy_start_en = 0; dup_en = 0; dup_val = 4'h0;
    abort_job = -1; abort_pix = 0;
  endtask

  // Job k finished (result taken or timeout decided) in cycle end_c.
  function automatic void record_end(int k, int end_c, logic [3:0] v, bit tmo);
    m_results[k*4 +: 4] = v;
    if (tmo) m_err = 1'b1;
    m_cur_until = end_c + 1;
    if (k < m_njobs - 1) begin
      feed_sel[end_c + 2 + GAP] = (m_base + k + 1) % NUM_SEL;
      feed_job[end_c + 2 + GAP] = k + 1;
    end else begin
      m_done_cyc = end_c + 2;
    end
  endfunction

  task automatic apply_reset(input bit check_outputs);
    chk_en = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    if (check_outputs) begin
      chk("rst_sel", o_sel, 0);
      chk("rst_feed_valid", o_feed_valid, 0);
      chk("rst_busy", o_busy, 0);
      chk("rst_done", o_done, 0);
      chk("rst_job_idx", o_job_idx, 0);
      chk("rst_results", o_results, 0);
      chk("rst_err", o_err, 0);
    end
    i_start = 0; i_pix_valid = 0; i_result_valid = 0;
    @(posedge clk);
    @(posedge clk);
    #4;
    reset = 1'b0;
    m_active = 0; m_done_cyc = -1; m_results = '0; m_err = 0;
    m_cur_until = -1;
    feed_sel.delete();
    feed_job.delete();
    step();
    chk_en = 1'b1;
  endtask

  task automatic start_batch(input int base, input int num);
    seen_sel.delete();
    i_base_sel  = 4'(base);
    i_num_jobs  = 3'(num);
    i_start     = 1'b1;
    m_start_cyc = cyc;
    m_base      = base % NUM_SEL;
    m_njobs     = (num == 0) ? 1 : ((num > MAXJ) ? MAXJ : num);
    m_results   = '0;
    m_err       = 1'b0;
    m_done_cyc  = BIG;
    feed_sel[cyc + 1] = m_base;
    feed_job[cyc + 1] = 0;
    m_active    = 1'b1;
    step();
    i_start = 1'b0;
  endtask

  task automatic run_batch(input int base, input int num, output bit ok);
    int w, npix, last_v, limit, end_c;
    ok = 1'b1;
    start_batch(base, num);
    for (int k = 0; k < m_njobs; k++) begin
      w = 0;
      while (o_feed_valid !== 1'b1 && w < FEED_WAIT) begin
        step();
        w++;
      end
      chk("feed_wait_in_budget", (w < FEED_WAIT), 1);
      if (w >= FEED_WAIT) begin
        apply_reset(1'b0);
        ok = 1'b0;
        return;
      end
      step();
      npix = 0;
      last_v = cyc;
      limit = (stall_after[k] >= 0) ? stall_after[k] : TOTAL;
      while (npix < limit) begin
        if (k == abort_job && npix == abort_pix) begin
          apply_reset(1'b1);
          ok = 1'b0;
          return;
        end
        i_pix_valid = (cyc % 7 != 3);
        if (i_pix_valid) begin
          npix++;
          last_v = cyc;
        end
        i_result_valid = stray_en && (cyc % 97 == 0);
        i_result       = 4'hA;
        i_start        = busy_start_en && (cyc % 113 == 0);
        step();
      end
      i_pix_valid = 0; i_result_valid = 0; i_start = 0;
      if (stall_after[k] >= 0) begin
        record_end(k, last_v + TIMEOUT, 4'hF, 1'b1);
      end else begin
        // Surplus pixel strobes after the last pixel must be ignored.
        i_pix_valid = 1; step();
        i_pix_valid = 1; step();
        i_pix_valid = 0;
        while (cyc < last_v + res_delay[k]) step();
        i_result_valid = 1; i_result = res_val[k];
        end_c = cyc;
        record_end(k, end_c, res_val[k], 1'b0);
        step();
        if (dup_en) begin
          i_result_valid = 1; i_result = dup_val;
          step();
        end
        i_result_valid = 0;
      end
    end
    w = 0;
    while (m_active && w < 64) begin
      step();
      w++;
    end
    repeat (2) step();
  endtask

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    bit fe;
    if (chk_en) begin
      fe = feed_sel.exists(cyc);
      if (o_feed_valid) seen_sel.push_back(int'(o_sel));
      chk("feed_valid", o_feed_valid, fe);
      if (fe) begin
        chk("sel_at_launch", o_sel, feed_sel[cyc]);
        chk("job_idx_at_launch", o_job_idx, feed_job[cyc]);
        m_cur_sel   = feed_sel[cyc];
        m_cur_from  = cyc;
        m_cur_until = BIG;
      end else if (m_active && cyc > m_cur_from && cyc <= m_cur_until) begin
        chk("sel_stable", o_sel, m_cur_sel);
      end
      chk("done", o_done, (cyc == m_done_cyc));
      chk("busy", o_busy, (m_active && cyc > m_start_cyc && cyc < m_done_cyc));
      if (cyc == m_done_cyc) begin
        chk("results_at_done", o_results, m_results);
        chk("err_at_done", o_err, m_err);
        chk("job_idx_at_done", o_job_idx, m_njobs - 1);
        m_active   = 1'b0;
        m_done_cyc = -1;
      end else if (!m_active) begin
        chk("idle_results", o_results, m_results);
        chk("idle_err", o_err, m_err);
        chk("idle_job_idx", o_job_idx, 0);
      end
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bit ok;
    clear_cfg();
    // Reset state while reset is held from time zero.
    #12;
    chk("rst_sel", o_sel, 0);
    chk("rst_feed_valid", o_feed_valid, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_done", o_done, 0);
    chk("rst_job_idx", o_job_idx, 0);
    chk("rst_results", o_results, 0);
    chk("rst_err", o_err, 0);
    @(posedge clk);
    #4;
    reset = 1'b0;
    step();
    chk_en = 1'b1;
    repeat (3) step();

    // Single job.
    clear_cfg();
    res_val[0] = 4'h5; res_delay[0] = 20;
    run_batch(3, 1, ok);
    chk("single_results_lit", o_results, 16'h0005);
    chk("single_err_lit", o_err, 0);
    chk("single_launch_count", seen_sel.size(), 1);
    if (seen_sel.size() == 1) chk("single_sel_lit", seen_sel[0], 3);

    // Four jobs with select wrap.
    clear_cfg();
    res_val[0] = 4'h1; res_val[1] = 4'h2; res_val[2] = 4'h3; res_val[3] = 4'h4;
    res_delay[0] = 20; res_delay[1] = 5; res_delay[2] = 9; res_delay[3] = 13;
    run_batch(10, 4, ok);
    chk("four_results_lit", o_results, 16'h4321);
    chk("four_launch_count", seen_sel.size(), 4);
    if (seen_sel.size() == 4) begin
      chk("four_sel0_lit", seen_sel[0], 10);
      chk("four_sel1_lit", seen_sel[1], 11);
      chk("four_sel2_lit", seen_sel[2], 0);
      chk("four_sel3_lit", seen_sel[3], 1);
    end

    // Clamping, out-of-range base, start pulses while busy.
    clear_cfg();
    busy_start_en = 1; res_val[0] = 4'hC;
    run_batch(14, 0, ok);
    chk("clamp0_launch_count", seen_sel.size(), 1);
    if (seen_sel.size() == 1) chk("clamp0_sel_lit", seen_sel[0], 2);
    clear_cfg();
    busy_start_en = 1;
    res_val[0] = 4'h9; res_val[1] = 4'h8; res_val[2] = 4'h7; res_val[3] = 4'h6;
    run_batch(0, 7, ok);
    chk("clamp7_launch_count", seen_sel.size(), 4);
    chk("clamp7_results_lit", o_results, 16'h6789);

    // Pixel timeout on job 0.
    clear_cfg();
    stall_after[0] = 100; res_val[1] = 4'h6;
    run_batch(0, 2, ok);
    chk("tmo_results_lit", o_results, 16'h006F);
    chk("tmo_err_lit", o_err, 1);

    // Stray results during streaming and a duplicate after the first.
    clear_cfg();
    stray_en = 1; dup_en = 1; res_val[0] = 4'h7; dup_val = 4'h9;
    run_batch(5, 1, ok);
    chk("stray_results_lit", o_results, 16'h0007);
    chk("stray_err_lit", o_err, 0);

    // Reset during streaming of job 1, then a normal batch.
    clear_cfg();
    res_val[0] = 4'h3; abort_job = 1; abort_pix = 50;
    run_batch(0, 2, ok);
    chk("post_reset_results", o_results, 16'h0000);
    clear_cfg();
    res_val[0] = 4'h8; res_val[1] = 4'h9;
    run_batch(7, 2, ok);
    chk("after_reset_results_lit", o_results, 16'h0098);
    chk("after_reset_launch_count", seen_sel.size(), 2);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fmap_job_sequencer.md
Name: fmap_job_sequencer

Overview:
- Sequences the pixel-ROM feeder and the CNN through a batch of 1..MAX_JOBS images (e.g. the four sub-cells of one braille character).
- Per job: drives the image-select lines, fires the feeder's one-cycle start, counts streamed pixels, waits for the CNN class result, and stores it.
- Sits between the top-level button/UART control and the feeder/cnn_top pair.
- Packs all results and flags timeouts.

Parameters:
- TOTAL_PIXELS, 784, pixels per image; the feeder's IX*IY.
- SEL_BW, 4, image-select width.
- NUM_SEL, 12, number of valid image indices (0..NUM_SEL-1).
- CLASS_BW, 4, CNN result width.
- MAX_JOBS, 4, maximum images per batch.
- TIMEOUT, 4095, idle cycles tolerated while streaming or awaiting a result.
- GAP, 2, idle cycles between jobs, so the feeder can return to its idle address.

Ports:
- clk  in  1  single clock; all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- i_start  in  1  batch start; sampled only in IDLE.
- i_base_sel  in  SEL_BW  first image index of the batch.
- i_num_jobs  in  3  images in the batch; 0 is treated as 1; values above MAX_JOBS are clamped to MAX_JOBS.
- o_sel  out  SEL_BW  image select to the feeder; stable for a whole job.
- o_feed_valid  out  1  one-cycle feeder start pulse.
- i_pix_valid  in  1  feeder pixel-valid strobe.
- i_result_valid  in  1  CNN result strobe.
- i_result  in  CLASS_BW  CNN class.
- o_busy  out  1  high from the cycle after start acceptance until o_done.
- o_done  out  1  one-cycle batch-complete pulse.
- o_job_idx  out  2  index of the current job.
- o_results  out  MAX_JOBS*CLASS_BW  job k result at bits [k*CLASS_BW +: CLASS_BW].
- o_err  out  1  sticky per batch; set by any timeout.

Behaviour:
- Reset (any time, including mid-batch): state IDLE; all outputs 0; counters 0. o_feed_valid drops in the same cycle reset asserts (asynchronous).
- States: IDLE, LAUNCH, STREAM, WAIT_RES, STORE, GAP_WAIT, DONE.
- IDLE, i_start=1:
  - Latch base and clamped count.
  - Clear o_results and o_err; set job=0.
  - o_sel = base, then go to LAUNCH.
  - With i_start asserted at edge N: o_busy=1 and o_feed_valid=1 in cycle N+1.
- LAUNCH: o_feed_valid=1 for exactly this cycle; pixel count and timer cleared; go to STREAM.
- STREAM:
  - Each i_pix_valid increments the pixel count and clears the timer.
  - Otherwise the timer increments.
  - When count reaches TOTAL_PIXELS (the 784th valid), go to WAIT_RES.
  - Timer == TIMEOUT: go to STORE with error.
  - i_pix_valid beyond TOTAL_PIXELS is ignored.
- WAIT_RES:
  - The first i_result_valid captures i_result and goes to STORE.
  - The timer increments each cycle; timer == TIMEOUT goes to STORE with error.
  - i_result_valid outside WAIT_RES is ignored.
- STORE:
  - Write the captured result into slot job. On error, write all-ones and set o_err.
  - If job == count-1, go to DONE.
  - Otherwise: job += 1; o_sel = (base + job) mod NUM_SEL, wrapping 11 -> 0 at the default; go to GAP_WAIT.
- GAP_WAIT: hold GAP cycles with o_feed_valid=0, then go to LAUNCH.
- DONE: o_done=1 for one cycle, then go to IDLE.
  - o_busy falls in the same cycle o_done rises.
  - o_results and o_err hold until the next accepted start.
- i_start is ignored in every state except IDLE.
- i_base_sel >= NUM_SEL is reduced modulo NUM_SEL at latch.
- o_job_idx = job in all states; 0 in IDLE.
- Untouched result slots read 0.

Test Plan:
- Reset mid-batch:
  - Stimulus: assert reset during STREAM of job 1.
  - Response: all outputs 0 immediately; next start behaves normally.
- Single job:
  - Stimulus: base=3, num=1, start pulse; model feeder gives 784 valids; CNN returns 5 twenty cycles later.
  - Response: o_sel=3 throughout; one o_feed_valid one cycle after start; o_results[3:0]=5; o_done once; o_err=0.
- Four jobs with wrap:
  - Stimulus: base=10, num=4; results 1,2,3,4.
  - Response: o_sel sequence 10,11,0,1, each preceded by GAP=2 idle cycles; o_results=16'h4321.
- Clamping:
  - Stimulus: num=0, then num=7.
  - Response: exactly 1 job, then exactly 4 jobs; i_start pulses during busy produce no extra jobs.
- Pixel timeout:
  - Stimulus: feeder stalls after 100 valids, num=2, second job normal with result 6.
  - Response: after 4095 idle cycles slot0=4'hF, o_err=1, job1 runs; o_results=16'h006F.
- Stray and duplicate results:
  - Stimulus: i_result_valid pulses during STREAM, plus two results in WAIT_RES (7 then 9).
  - Response: the STREAM pulses are ignored; only 7 is stored.
